clk_div_multi: RTL and testbench

Multi-channel programmable clock divider that produces N_CH independent divided drive clocks from CLKIN. Each channel has its own runtime-programmable half-period and phase offset. All channels share the active-low run gate SYN1OUT and a common resync strobe. New ratios are applied only at a channel's toggle boundary, so outputs never glitch. It sits between the system clock and the driver stage, generalising the single fixed /102 DRV2 generator.

---
 rtl/clk_div_multi.sv | 95 +++++++++
 tb/tb_clk_div_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent programmable clock dividers sharing a run gate and a
// resync strobe. New ratios are taken only at a channel's toggle boundary, so DRV never glitches.
module clk_div_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 50,
    parameter int STOP_CLR = 0,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLKIN,
    input  logic             Reset,
    input  logic             SYN1OUT,
    input  logic             resync,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic [N_CH-1:0]  cfg_pending,
    output logic [N_CH-1:0]  DRV
);

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] r_cnt    [N_CH];
    logic [CNT_W-1:0] r_active [N_CH];
    logic [CNT_W-1:0] r_shadow [N_CH];
    logic [CNT_W-1:0] r_phase  [N_CH];
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  r_drv;

    logic             w_chValid;
    logic [N_CH-1:0]  w_wrHit;
    logic [N_CH-1:0]  w_atTerm;
    logic [CNT_W-1:0] w_resyncHalf [N_CH];
    logic [CNT_W-1:0] w_resyncCnt  [N_CH];

    // A resync with a pending shadow adopts the new half first and clamps the phase against it.
    always_comb begin
        w_chValid = (int'(cfg_ch) < N_CH);
        w_wrHit   = '0;
        w_atTerm  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wrHit[i]      = cfg_wr && w_chValid && (int'(cfg_ch) == i);
            w_atTerm[i]     = (r_cnt[i] == r_active[i]);
            w_resyncHalf[i] = r_pending[i] ? r_shadow[i] : r_active[i];
            w_resyncCnt[i]  = (r_phase[i] < w_resyncHalf[i]) ? r_phase[i] : w_resyncHalf[i];
        end
    end

    // The config write is evaluated last so a coincident write always lands as pending.
    always_ff @(posedge CLKIN or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]    <= '0;
                r_active[i] <= DEF_HALF_V;
                r_shadow[i] <= DEF_HALF_V;
                r_phase[i]  <= '0;
            end
            r_pending <= '0;
            r_drv     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (resync) begin
                    r_cnt[i]     <= w_resyncCnt[i];
                    r_drv[i]     <= 1'b0;
                    r_active[i]  <= w_resyncHalf[i];
                    r_pending[i] <= 1'b0;
                end else if (!SYN1OUT) begin
                    if (w_atTerm[i]) begin
                        r_cnt[i] <= '0;
                        r_drv[i] <= ~r_drv[i];
                        if (r_pending[i]) begin
                            r_active[i]  <= r_shadow[i];
                            r_pending[i] <= 1'b0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else if (STOP_CLR != 0) begin
                    r_drv[i] <= 1'b0;
                end

                if (w_wrHit[i]) begin
                    r_shadow[i]  <= cfg_half;
                    r_phase[i]   <= cfg_phase;
                    r_pending[i] <= 1'b1;
                end
            end
        end
    end

    assign DRV         = r_drv;
    assign cfg_pending = r_pending;

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed ratio/phase/gate/reset scenarios plus random traffic,
// all compared every cycle against a countdown-based reference model.
module tb_clk_div_multi;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 50;

    logic             CLKIN = 1'b0;
    logic             Reset = 1'b0;
    logic             SYN1OUT = 1'b0;
    logic             resync = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [CNT_W-1:0] cfg_phase = '0;
    logic [N_CH-1:0]  cfg_pending;
    logic [N_CH-1:0]  DRV;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    // Model: edges left until the next toggle, plus output level and config state.
    int mRemain [N_CH];
    int mActive [N_CH];
    int mShadow [N_CH];
    int mPhase  [N_CH];
    bit mLevel  [N_CH];
    bit mPend   [N_CH];

    clk_div_multi #(
        .N_CH(N_CH),
        .CNT_W(CNT_W),
        .DEF_HALF(DEF_HALF),
        .STOP_CLR(0)
    ) dut (
        .CLKIN(CLKIN),
        .Reset(Reset),
        .SYN1OUT(SYN1OUT),
        .resync(resync),
        .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch),
        .cfg_half(cfg_half),
        .cfg_phase(cfg_phase),
        .cfg_pending(cfg_pending),
        .DRV(DRV)
    );

    always #5 CLKIN = ~CLKIN;

    function automatic void resetModel();
        for (int i = 0; i < N_CH; i++) begin
            mRemain[i] = DEF_HALF + 1;
            mActive[i] = DEF_HALF;
            mShadow[i] = DEF_HALF;
            mPhase[i]  = 0;
            mLevel[i]  = 1'b0;
            mPend[i]   = 1'b0;
        end
    endfunction

    function automatic logic [N_CH-1:0] expDrv();
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i] = mLevel[i];
        return v;
    endfunction

    function automatic logic [N_CH-1:0] expPend();
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i] = mPend[i];
        return v;
    endfunction

    // The model reacts to reset asynchronously and otherwise steps once per rising edge.
    always @(negedge Reset) resetModel();

    always @(posedge CLKIN) begin
        if (!Reset) begin
            resetModel();
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                int h;
                int p;
                if (resync) begin
                    h = mPend[i] ? mShadow[i] : mActive[i];
                    mActive[i] = h;
                    mPend[i]   = 1'b0;
                    p = (mPhase[i] < h) ? mPhase[i] : h;
                    mRemain[i] = h - p + 1;
                    mLevel[i]  = 1'b0;
                end else if (!SYN1OUT) begin
                    mRemain[i] = mRemain[i] - 1;
                    if (mRemain[i] == 0) begin
                        mLevel[i] = !mLevel[i];
                        if (mPend[i]) begin
                            mActive[i] = mShadow[i];
                            mPend[i]   = 1'b0;
                        end
                        mRemain[i] = mActive[i] + 1;
                    end
                end
                if (cfg_wr && int'(cfg_ch) == i) begin
                    mShadow[i] = int'(cfg_half);
                    mPhase[i]  = int'(cfg_phase);
                    mPend[i]   = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] ch, input logic [CNT_W-1:0] half,
                                 input logic [CNT_W-1:0] phase, input logic rs, input logic syn);
        cfg_wr    = wr;
        cfg_ch    = ch;
        cfg_half  = half;
        cfg_phase = phase;
        resync    = rs;
        SYN1OUT   = syn;
    endtask

    // Counts rising edges until DRV[ch] changes; must be called right after a falling edge.
    task automatic waitToggle(input int ch, input int maxEdges, output int n);
        logic prev;
        prev = DRV[ch];
        n = 0;
        do begin
            @(posedge CLKIN);
            n++;
            @(negedge CLKIN);
        end while (DRV[ch] === prev && n < maxEdges);
    endtask

    always @(negedge CLKIN) begin
        if (checkEn) begin
            checkOutput("model_DRV", 32'(DRV), 32'(expDrv()));
            checkOutput("model_cfg_pending", 32'(cfg_pending), 32'(expPend()));
        end
    end

    initial begin
        int n;
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        Reset = 1'b0;
        repeat (3) @(negedge CLKIN);
        checkEn = 1'b1;
        checkOutput("reset_DRV", 32'(DRV), 32'd0);
        checkOutput("reset_pending", 32'(cfg_pending), 32'd0);

        $display("[TB] default ratio after reset release");
        Reset = 1'b1;
        waitToggle(0, 200, n);
        checkOutput("first_rise_edge", n, 51);
        checkOutput("all_rise_together", 32'(DRV), 32'hF);
        waitToggle(0, 200, n);
        checkOutput("first_fall_delta", n, 51);

        $display("[TB] ch1 reprogrammed mid-period");
        repeat (10) @(negedge CLKIN);
        applyStimulus(1'b1, 2'd1, 8'd4, 8'd0, 1'b0, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("ch1_pending_set", 32'(cfg_pending), 32'h2);
        waitToggle(1, 200, n);
        checkOutput("ch1_old_half_finish", n, 40);
        checkOutput("ch1_pending_clear", 32'(cfg_pending[1]), 32'd0);
        waitToggle(1, 200, n);
        checkOutput("ch1_new_half_a", n, 5);
        waitToggle(1, 200, n);
        checkOutput("ch1_new_half_b", n, 5);

        $display("[TB] ch2 phase and resync");
        applyStimulus(1'b1, 2'd2, 8'd9, 8'd5, 1'b0, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("ch2_resync_low", 32'(DRV[2]), 32'd0);
        waitToggle(2, 200, n);
        checkOutput("ch2_phase5_first", n, 5);
        waitToggle(2, 200, n);
        checkOutput("ch2_half9", n, 10);
        applyStimulus(1'b1, 2'd2, 8'd9, 8'd200, 1'b0, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        waitToggle(2, 200, n);
        checkOutput("ch2_phase_clamp", n, 1);

        $display("[TB] gate ch3 mid-period");
        waitToggle(3, 200, n);
        repeat (20) @(negedge CLKIN);
        SYN1OUT = 1'b1;
        repeat (30) @(negedge CLKIN);
        SYN1OUT = 1'b0;
        waitToggle(3, 200, n);
        checkOutput("ch3_gate_resume", n, 31);

        $display("[TB] write coincident with ch0 boundary");
        for (int k = 0; k < 300 && mRemain[0] != 1; k++) @(negedge CLKIN);
        applyStimulus(1'b1, 2'd0, 8'd3, 8'd2, 1'b0, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("ch0_bnd_pending", 32'(cfg_pending[0]), 32'd1);
        waitToggle(0, 200, n);
        checkOutput("ch0_bnd_old_ratio", n, 51);
        checkOutput("ch0_bnd_pending_clear", 32'(cfg_pending[0]), 32'd0);
        waitToggle(0, 200, n);
        checkOutput("ch0_bnd_new_ratio", n, 4);

        $display("[TB] write coincident with resync");
        applyStimulus(1'b1, 2'd0, 8'd7, 8'd0, 1'b1, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("ch0_rs_low", 32'(DRV[0]), 32'd0);
        checkOutput("ch0_rs_pending", 32'(cfg_pending[0]), 32'd1);
        waitToggle(0, 200, n);
        checkOutput("ch0_rs_old_phase", n, 2);
        waitToggle(0, 200, n);
        checkOutput("ch0_rs_new_ratio", n, 8);

        $display("[TB] asynchronous reset mid-period");
        applyStimulus(1'b1, 2'd1, 8'd6, 8'd0, 1'b0, 1'b0);
        @(negedge CLKIN);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("pre_reset_pending", 32'(cfg_pending), 32'h2);
        @(negedge CLKIN);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("async_reset_DRV", 32'(DRV), 32'd0);
        checkOutput("async_reset_pending", 32'(cfg_pending), 32'd0);
        repeat (2) @(negedge CLKIN);
        Reset = 1'b1;
        waitToggle(1, 200, n);
        checkOutput("ch1_default_after_reset", n, 51);

        $display("[TB] random traffic");
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLKIN);
            #2;
            cfg_wr    = ($urandom_range(0, 15) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_half  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 12));
            cfg_phase = 8'($urandom_range(0, 255));
            resync    = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) SYN1OUT = ~SYN1OUT;
            Reset     = ($urandom_range(0, 999) != 0);
        end
        @(negedge CLKIN);
        #2;
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        Reset = 1'b1;
        repeat (4) @(negedge CLKIN);
        checkEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
